// File: rtl/epb_wb_responder_if.sv
// rtl/epb_wb_responder_if.sv - EPB host side and Wishbone fabric side signals of the responder
// EPB vectors carry EPB bit i on vector index (width-1-i), so EPB bit 0 is the vector MSB.
interface epb_wb_responder_if #(parameter int ADDR_WIDTH = 25);
   logic                  epb_cs_n;
   logic                  epb_r_w_n;
   logic [3:0]            epb_be_n;
   logic [ADDR_WIDTH-1:0] epb_addr;
   logic [31:0]           epb_data_i;
   logic [31:0]           epb_data_o;
   logic                  epb_data_oe_n;
   logic                  epb_rdy;
   logic                  wb_cyc_o;
   logic                  wb_stb_o;
   logic                  wb_we_o;
   logic [3:0]            wb_sel_o;
   logic [ADDR_WIDTH-1:0] wb_adr_o;
   logic [31:0]           wb_dat_o;
   logic [31:0]           wb_dat_i;
   logic                  wb_ack_i;
   logic                  wb_err_i;
   logic                  bus_err;

   modport slave (
      input  epb_cs_n, epb_r_w_n, epb_be_n, epb_addr, epb_data_i,
      output epb_data_o, epb_data_oe_n, epb_rdy,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
      input  wb_dat_i, wb_ack_i, wb_err_i,
      output bus_err
   );

   modport master (
      output epb_cs_n, epb_r_w_n, epb_be_n, epb_addr, epb_data_i,
      input  epb_data_o, epb_data_oe_n, epb_rdy,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
      output wb_dat_i, wb_ack_i, wb_err_i,
      input  bus_err
   );
endinterface

// File: rtl/epb_wb_responder.sv
// rtl/epb_wb_responder.sv - EPB chip-select cycles to single Wishbone accesses, epb_clk domain
// Registered inputs feed one FSM; every bus-facing output is a register.
module epb_wb_responder #(
   parameter int          ADDR_WIDTH = 25,
   parameter int          TIMEOUT    = 1023,
   parameter logic [31:0] ERR_DATA   = 32'hFFFF_FFFF
) (
   input logic              epb_clk,
   input logic              epb_rst,
   epb_wb_responder_if.slave bus
);

   localparam int             CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DRIVE, S_RESP, S_DONE} state_t;

   logic                  cs_n_q, r_w_n_q, in_vld_q;
   logic [3:0]            be_n_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           data_q;

   state_t                state_q;
   logic                  cyc_q, we_q, oe_n_q, rdy_q, bus_err_q, abort_q, armed_q;
   logic [3:0]            sel_q;
   logic [ADDR_WIDTH-1:0] adr_q;
   logic [31:0]           wdat_q, rdat_q;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  fault;

   always_ff @(posedge epb_clk or posedge epb_rst) begin
      if (epb_rst) begin
         cs_n_q   <= 1'b1;
         r_w_n_q  <= 1'b1;
         be_n_q   <= 4'hF;
         addr_q   <= '0;
         data_q   <= '0;
         in_vld_q <= 1'b0;
      end else begin
         cs_n_q   <= bus.epb_cs_n;
         r_w_n_q  <= bus.epb_r_w_n;
         be_n_q   <= bus.epb_be_n;
         addr_q   <= bus.epb_addr;
         data_q   <= bus.epb_data_i;
         in_vld_q <= 1'b1;
      end
   end

   always_comb begin
      cnt_d = (cnt_q == TMO_LAST) ? cnt_q : cnt_q + 1'b1;
      fault = bus.wb_err_i || (cnt_q == TMO_LAST);
   end

   // armed_q is only set from a genuinely sampled cs_n high, never from the reset value
   always_ff @(posedge epb_clk or posedge epb_rst) begin
      if (epb_rst) begin
         state_q   <= S_IDLE;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         adr_q     <= '0;
         wdat_q    <= '0;
         rdat_q    <= '0;
         oe_n_q    <= 1'b1;
         rdy_q     <= 1'b0;
         bus_err_q <= 1'b0;
         abort_q   <= 1'b0;
         armed_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         rdy_q     <= 1'b0;
         bus_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               abort_q <= 1'b0;
               oe_n_q  <= 1'b1;
               if (in_vld_q && cs_n_q) begin
                  armed_q <= 1'b1;
               end else if (armed_q && !cs_n_q) begin
                  armed_q <= 1'b0;
                  adr_q   <= addr_q;
                  we_q    <= ~r_w_n_q;
                  sel_q   <= ~be_n_q;
                  wdat_q  <= data_q;
                  cnt_q   <= '0;
                  cyc_q   <= 1'b1;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_d;
               if (cs_n_q) abort_q <= 1'b1;
               if (bus.wb_ack_i || fault) begin
                  cyc_q <= 1'b0;
                  if (bus.wb_ack_i) begin
                     if (!we_q) rdat_q <= bus.wb_dat_i;
                  end else begin
                     bus_err_q <= 1'b1;
                     if (!we_q) rdat_q <= ERR_DATA;
                  end
                  if (abort_q || cs_n_q) begin
                     state_q <= S_DONE;
                  end else if (we_q) begin
                     state_q <= S_RESP;
                     rdy_q   <= 1'b1;
                  end else begin
                     state_q <= S_DRIVE;
                     oe_n_q  <= 1'b0;
                  end
               end
            end
            S_DRIVE: begin
               state_q <= S_RESP;
               rdy_q   <= 1'b1;
            end
            S_RESP: begin
               state_q <= S_DONE;
               oe_n_q  <= 1'b1;
            end
            S_DONE: begin
               oe_n_q <= 1'b1;
               if (cs_n_q) begin
                  state_q <= S_IDLE;
                  armed_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // EPB bit i sits on vector index 31-i, so plain vector copies realise the bit-reversed mapping
   always_comb begin
      bus.wb_cyc_o      = cyc_q;
      bus.wb_stb_o      = cyc_q;
      bus.wb_we_o       = we_q;
      bus.wb_sel_o      = sel_q;
      bus.wb_adr_o      = adr_q;
      bus.wb_dat_o      = wdat_q;
      bus.epb_data_o    = rdat_q;
      bus.epb_data_oe_n = oe_n_q;
      bus.epb_rdy       = rdy_q;
      bus.bus_err       = bus_err_q;
   end

endmodule

// File: tb/tb_epb_wb_responder.sv
// tb/tb_epb_wb_responder.sv - scoreboard bench for epb_wb_responder
// Vectors are WB-side values; EPB bit i is vector index (width-1-i) on the EPB side.
module tb_epb_wb_responder;
   localparam int          AW   = 25;
   localparam int          TMO  = 15;
   localparam logic [31:0] ERRD = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   epb_wb_responder_if #(.ADDR_WIDTH(AW)) bus();

   epb_wb_responder #(.ADDR_WIDTH(AW), .TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
      .epb_clk (clk),
      .epb_rst (rst),
      .bus     (bus.slave)
   );

   typedef struct {logic we; logic [3:0] sel; logic [AW-1:0] adr; logic [31:0] dat; int len;} fab_t;
   typedef struct {logic rd; logic [31:0] dat; int errs; int lat;} rsp_t;

   fab_t fab_q[$];
   rsp_t rsp_q[$];
   fab_t cur;
   int n_cmp = 0, n_fail = 0;
   int edge_n = 0, cs_edge = 0;
   int rdy_cnt = 0, oe_cnt = 0, err_cnt = 0, err_mark = 0, cyc_starts = 0, mon_len = 0;
   logic prev_cyc = 1'b0, prev_oe_n = 1'b1;
   int fab_wait = 0, fab_mode = 1, fab_cnt = 0;
   logic [31:0] fab_rdata = '0;
   int snap_rdy, snap_oe, snap_err, snap_cyc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) edge_n++;

   // fabric model: mode 0 never answers, 1 ack, 2 err, 3 ack and err together
   always @(negedge clk) begin
      if (bus.wb_stb_o) begin
         if (fab_cnt == fab_wait && fab_mode != 0) begin
            bus.wb_ack_i = (fab_mode == 1 || fab_mode == 3);
            bus.wb_err_i = (fab_mode >= 2);
            bus.wb_dat_i = fab_rdata;
         end else begin
            bus.wb_ack_i = 1'b0;
            bus.wb_err_i = 1'b0;
            bus.wb_dat_i = 32'hDEAD_BEEF;
         end
         fab_cnt++;
      end else begin
         fab_cnt      = 0;
         bus.wb_ack_i = 1'b0;
         bus.wb_err_i = 1'b0;
         bus.wb_dat_i = 32'hDEAD_BEEF;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.bus_err) err_cnt++;
         if (!bus.epb_data_oe_n) oe_cnt++;
         if (bus.wb_cyc_o && !prev_cyc) begin
            cyc_starts++;
            mon_len = 1;
            if (fab_q.size() == 0) begin
               n_cmp++; n_fail++;
               cur.len = 0;
               $display("FAIL fab_unexpected: got cycle at edge %0d expected none", edge_n);
            end else begin
               cur = fab_q.pop_front();
               chk("wb_stb_o", bus.wb_stb_o, 1);
               chk("wb_we_o", bus.wb_we_o, cur.we);
               chk("wb_sel_o", bus.wb_sel_o, cur.sel);
               chk("wb_adr_o", bus.wb_adr_o, cur.adr);
               chk("wb_dat_o", bus.wb_dat_o, cur.dat);
               chk("stb_latency", edge_n + 1 - cs_edge, 2);
            end
         end else if (bus.wb_cyc_o) begin
            mon_len++;
         end else if (prev_cyc) begin
            chk("cyc_len", mon_len, cur.len);
         end
         if (bus.epb_rdy) begin
            rsp_t r;
            rdy_cnt++;
            if (rsp_q.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL rdy_unexpected: got rdy at edge %0d expected none", edge_n);
            end else begin
               r = rsp_q.pop_front();
               chk("rdy_latency", edge_n + 1 - cs_edge, r.lat);
               chk("bus_err_pulses", err_cnt - err_mark, r.errs);
               if (r.rd) begin
                  chk("epb_data_o", bus.epb_data_o, r.dat);
                  chk("oe_n_at_rdy", bus.epb_data_oe_n, 0);
                  chk("oe_n_before_rdy", prev_oe_n, 0);
               end else begin
                  chk("oe_n_write", bus.epb_data_oe_n, 1);
               end
            end
            err_mark = err_cnt;
         end
      end
      prev_cyc  = bus.wb_cyc_o;
      prev_oe_n = bus.epb_data_oe_n;
   end

   task automatic start_cycle(input bit rd, input logic [3:0] be_n, input logic [AW-1:0] adr,
                              input logic [31:0] wdat, input int wt, input int mode,
                              input logic [31:0] rdat, input int len);
      @(negedge clk);
      fab_wait = wt; fab_mode = mode; fab_rdata = rdat;
      bus.epb_r_w_n = rd; bus.epb_be_n = be_n; bus.epb_addr = adr; bus.epb_data_i = wdat;
      bus.epb_cs_n = 1'b0;
      cs_edge = edge_n + 1;
      fab_q.push_back('{!rd, ~be_n, adr, wdat, len});
   endtask

   task automatic xfer(input bit rd, input logic [3:0] be_n, input logic [AW-1:0] adr,
                       input logic [31:0] wdat, input int wt, input int mode, input logic [31:0] rdat);
      int len, lat, errs;
      logic [31:0] dexp;
      len  = (mode == 0) ? TMO + 1 : wt + 1;
      lat  = (rd ? 4 : 3) + len - 1;
      errs = (mode == 0 || mode == 2) ? 1 : 0;
      dexp = (mode == 1 || mode == 3) ? rdat : ERRD;
      start_cycle(rd, be_n, adr, wdat, wt, mode, rdat, len);
      rsp_q.push_back('{rd, dexp, errs, lat});
      repeat (lat) @(negedge clk);
      bus.epb_cs_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      bus.epb_cs_n = 1'b1; bus.epb_r_w_n = 1'b1; bus.epb_be_n = 4'hF;
      bus.epb_addr = '0; bus.epb_data_i = '0;
      repeat (3) @(negedge clk);
      chk("rst_cyc", bus.wb_cyc_o, 0);
      chk("rst_stb", bus.wb_stb_o, 0);
      chk("rst_we", bus.wb_we_o, 0);
      chk("rst_sel", bus.wb_sel_o, 0);
      chk("rst_adr", bus.wb_adr_o, 0);
      chk("rst_dat_o", bus.wb_dat_o, 0);
      chk("rst_data_o", bus.epb_data_o, 0);
      chk("rst_oe_n", bus.epb_data_oe_n, 1);
      chk("rst_rdy", bus.epb_rdy, 0);
      chk("rst_bus_err", bus.bus_err, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      snap_rdy = rdy_cnt; snap_oe = oe_cnt;
      xfer(1'b0, 4'b0000, 25'h000010, 32'h1234_5678, 2, 1, 32'h0);
      chk("write_rdy_pulses", rdy_cnt - snap_rdy, 1);
      chk("write_oe_cycles", oe_cnt - snap_oe, 0);

      snap_oe = oe_cnt;
      xfer(1'b1, 4'b0000, 25'h1ABCDE, 32'h0, 0, 1, 32'hCAFE_F00D);
      chk("read_oe_cycles", oe_cnt - snap_oe, 2);

      xfer(1'b0, 4'b1010, 25'h0F0F0F, 32'hA5A5_5A5A, 0, 1, 32'h0);
      chk("data_o_hold", bus.epb_data_o, 32'hCAFE_F00D);

      snap_rdy = rdy_cnt;
      xfer(1'b1, 4'b0011, 25'h155555, 32'h0, 0, 0, 32'h0);
      chk("timeout_rdy_pulses", rdy_cnt - snap_rdy, 1);

      xfer(1'b0, 4'b1110, 25'h0AAAAA, 32'h0BAD_C0DE, 1, 2, 32'h0);
      xfer(1'b1, 4'b0000, 25'h1000000, 32'h0, 1, 3, 32'h0F0F_1234);

      snap_rdy = rdy_cnt; snap_oe = oe_cnt; snap_err = err_cnt;
      start_cycle(1'b1, 4'b0000, 25'h000123, 32'h0, 5, 1, 32'h55AA_55AA, 6);
      repeat (3) @(negedge clk);
      bus.epb_cs_n = 1'b1;
      repeat (15) @(negedge clk);
      chk("abort_rdy", rdy_cnt - snap_rdy, 0);
      chk("abort_oe", oe_cnt - snap_oe, 0);
      chk("abort_err", err_cnt - snap_err, 0);
      xfer(1'b1, 4'b0000, 25'h000124, 32'h0, 0, 1, 32'h1357_9BDF);

      start_cycle(1'b1, 4'b0000, 25'h000200, 32'h0, 0, 1, 32'h1111_2222, 1);
      repeat (3) @(negedge clk);
      chk("drive_oe_n", bus.epb_data_oe_n, 0);
      rst = 1'b1;
      #1;
      chk("rst_drive_oe_n", bus.epb_data_oe_n, 1);
      chk("rst_drive_rdy", bus.epb_rdy, 0);
      chk("rst_drive_cyc", bus.wb_cyc_o, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      snap_cyc = cyc_starts; snap_rdy = rdy_cnt;
      repeat (10) @(negedge clk);
      chk("cs_low_after_rst_cyc", cyc_starts - snap_cyc, 0);
      chk("cs_low_after_rst_rdy", rdy_cnt - snap_rdy, 0);
      bus.epb_cs_n = 1'b1;
      repeat (2) @(negedge clk);
      xfer(1'b0, 4'b0101, 25'h0C0FFE, 32'hFEED_0001, 0, 1, 32'h0);

      repeat (5) @(negedge clk);
      chk("fab_q_empty", fab_q.size(), 0);
      chk("rsp_q_empty", rsp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/epb_wb_responder.md
Name: epb_wb_responder

Overview:
EPB bus responder: turns PowerPC EPB chip-select cycles into single Wishbone-style register accesses on the fabric side, then returns ready and read data to the EPB host. Sits directly behind the EPB pad/clock infrastructure. Takes the buffered input data bus, drives the output-data and output-enable lines back into the IOBUFs, and runs entirely in the epb_clk domain (BUFG'd per_clk).

Parameters:
ADDR_WIDTH, 25, width of epb_addr and wb_adr_o (word address)
TIMEOUT, 1023, fabric cycles to wait for ack/err before forcing completion (>=2)
ERR_DATA, 32'hFFFF_FFFF, read data returned on timeout or wb_err_i

Ports:
epb_clk  in  1  EPB clock, all logic rising-edge
epb_rst  in  1  asynchronous, active-high reset
epb_cs_n  in  1  EPB chip select, active low
epb_r_w_n  in  1  1 = read, 0 = write
epb_be_n  in  4  [0:3] byte enables, active low; bit 0 = data[0:7]
epb_addr  in  ADDR_WIDTH  [0:ADDR_WIDTH-1] word address, MSB at index 0
epb_data_i  in  32  [0:31] data from pad buffers
epb_data_o  out  32  [0:31] read data to pad buffers
epb_data_oe_n  out  1  pad tristate control, 0 = FPGA drives
epb_rdy  out  1  transfer-complete strobe to host
wb_cyc_o  out  1  fabric cycle
wb_stb_o  out  1  fabric strobe
wb_we_o  out  1  fabric write enable
wb_sel_o  out  4  [3:0] byte selects
wb_adr_o  out  ADDR_WIDTH  [ADDR_WIDTH-1:0] address
wb_dat_o  out  32  [31:0] write data
wb_dat_i  in  32  [31:0] read data
wb_ack_i  in  1  fabric acknowledge
wb_err_i  in  1  fabric error
bus_err  out  1  one-cycle pulse on timeout or wb_err_i

Behaviour:
- Reset (async, any state): state IDLE; wb_cyc_o/stb_o/we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0, epb_data_o=0, epb_data_oe_n=1, epb_rdy=0, bus_err=0, abort flag clear, timeout counter 0.
- Input stage: cs_n, r_w_n, be_n, addr and data_i are registered once. The FSM sees only the registered copies. cs_n register resets to 1.
- Bit mapping: EPB bit i maps to WB bit 31-i for data and ADDR_WIDTH-1-i for address. wb_sel_o[3-k] = ~epb_be_n[k].
- IDLE: when registered cs_n=0, latch adr/we(=~r_w_n)/sel/dat_o and go to WAIT. cyc=stb=1 from the next cycle.
- WAIT: cyc=stb=1; the counter increments each cycle.
  - ack_i: capture wb_dat_i (reads) into epb_data_o, bit-reversed.
  - err_i or counter==TIMEOUT: load ERR_DATA for reads and pulse bus_err.
  - ack_i wins over a same-cycle err_i or timeout.
  - On completion, cyc/stb drop the next cycle. Next state: DRIVE for reads, RESP for writes; DONE if the abort flag is set.
- Abort: registered cs_n=1 seen in WAIT sets the abort flag. The fabric cycle still runs to completion, but no oe/rdy is produced. The flag clears in IDLE.
- DRIVE (reads only): epb_data_oe_n=0, epb_rdy=0. This is one cycle of bus turnaround/setup.
- RESP: epb_rdy=1 for exactly one cycle; epb_data_oe_n=0 for reads, 1 for writes.
- DONE: epb_data_oe_n=1, epb_rdy=0. Waits for registered cs_n=1, then goes to IDLE. A new cycle is never started without cs_n first returning high.
- Latency: cs_n low at input edge N with zero-wait ack gives stb high at N+2. Writes: rdy at N+3. Reads: oe_n low at N+3, rdy at N+4.
- epb_data_o holds its value until the next read completes. wb_dat_o/adr/sel hold after the cycle.
- The timeout counter saturates and clears on entry to WAIT.

Test Plan:
- Write addr 0x000010, data 0x12345678, be_n=0000, ack after 2 wait cycles -> wb_adr_o=0x000010 (bit-reversed mapping checked), wb_we_o=1, wb_sel_o=F, exactly one rdy pulse, oe_n stays 1.
- Read with zero-wait ack, wb_dat_i=0xCAFEF00D -> oe_n low one cycle before and during rdy; epb_data_o equals the bit-reversed 0xCAFEF00D; rdy at N+4.
- Read with no ack, TIMEOUT=15 -> cyc high 16 cycles, bus_err one pulse, epb_data_o = bit-reversed 0xFFFFFFFF, rdy pulses once.
- Same-cycle wb_ack_i and wb_err_i -> treated as ack, no bus_err.
- cs_n raised mid-WAIT, then ack -> no rdy, oe_n stays 1, FSM returns to IDLE. A following cycle completes normally.
- epb_rst asserted in DRIVE -> oe_n=1, rdy=0, cyc=0 immediately. After release, cs_n held low does not start a cycle until it has been seen high.
